lsu_wb_master: RTL



---
 rtl/lsu_pkg.sv | 22 ++
 rtl/lsu_wb_timeout.sv | 30 +++
 rtl/lsu_wb_master.sv | 130 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: FSM encoding of
// the Wishbone master, datapath widths, and the load-format funct3 codes the
// formatter uses when it extends the raw word returned by the master.
package lsu_pkg;

  localparam int XLEN  = 32;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Load formatter funct3 codes (RV32I encoding).
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/lsu_wb_timeout.sv
// Bus-cycle watchdog for lsu_wb_master: counts cycles spent in BUS and flags
// the cycle in which the TIMEOUT_CYCLES-th BUS cycle is running.
module lsu_wb_timeout
  #(parameter int TIMEOUT_CYCLES = 255)
  (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic active_i,
    output logic expired_o
  );

  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // Count BUS cycles; restart from zero whenever a new bus cycle is launched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (start_i) begin
      count <= '0;
    end else if (active_i) begin
      count <= count + 16'd1;
    end
  end

  assign expired_o = active_i & (count == LAST);

endmodule

// File: rtl/lsu_wb_master.sv
// Memory-stage Wishbone classic master: one request at a time, IDLE -> BUS ->
// RESP, stalling the pipeline until the response strobe. The optional bus
// watchdog is enabled by defining LSU_WB_TIMEOUT_EN.
module lsu_wb_master
  import lsu_pkg::*;
  #(parameter int TIMEOUT_CYCLES = 255)
  (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    input  logic                req_we_i,
    input  logic [XLEN-1:0]     addr_i,
    input  logic [XLEN-1:0]     st_data_i,
    input  logic [SEL_W-1:0]    st_sel_i,
    input  logic                misaligned_i,
    input  logic                kill_i,
    output logic                stall_o,
    output logic                done_o,
    output logic [XLEN-1:0]     ld_data_o,
    output logic                bus_err_o,
    output logic [XLEN-1:0]     wbm_adr_o,
    output logic [XLEN-1:0]     wbm_dat_o,
    output logic [SEL_W-1:0]    wbm_sel_o,
    output logic                wbm_we_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    input  logic [XLEN-1:0]     wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i
  );

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_cycles
    $error("lsu_wb_master: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t state, state_next;
  logic   accept;
  logic   timeout;
  logic   bus_end;
  logic   bus_fault;
  logic   killed;
  logic   kill_now;

  // A request is only launched for a live, aligned memory instruction.
  assign accept    = req_valid_i & ~misaligned_i & ~kill_i;
  assign stall_o   = ((state == IDLE) & accept) | (state == BUS);
  assign wbm_stb_o = wbm_cyc_o;

`ifdef LSU_WB_TIMEOUT_EN
  lsu_wb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   ((state == IDLE) & accept),
    .active_i  (state == BUS),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // A slave answer in the watchdog cycle beats the watchdog; err beats ack.
  assign bus_end   = wbm_ack_i | wbm_err_i | timeout;
  assign bus_fault = wbm_err_i | (timeout & ~wbm_ack_i);
  // Wishbone cannot abort, so a flush only silences the response.
  assign kill_now  = killed | kill_i;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)  state_next = BUS;
      BUS:     if (bus_end) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus request registers, response strobes and the load return word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      wbm_we_o  <= 1'b0;
      wbm_cyc_o <= 1'b0;
      done_o    <= 1'b0;
      bus_err_o <= 1'b0;
      ld_data_o <= '0;
      killed    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wbm_adr_o <= {addr_i[XLEN-1:2], 2'b00};
            wbm_dat_o <= st_data_i;
            wbm_sel_o <= req_we_i ? st_sel_i : {SEL_W{1'b1}};
            wbm_we_o  <= req_we_i;
            wbm_cyc_o <= 1'b1;
            killed    <= 1'b0;
          end
        end
        BUS: begin
          killed <= kill_now;
          if (bus_end) begin
            wbm_cyc_o <= 1'b0;
            done_o    <= ~kill_now;
            bus_err_o <= bus_fault & ~kill_now;
            if (!bus_fault && !wbm_we_o) ld_data_o <= wbm_dat_i;
          end
        end
        RESP: begin
          done_o    <= 1'b0;
          bus_err_o <= 1'b0;
        end
        default: begin
          done_o    <= 1'b0;
          bus_err_o <= 1'b0;
          wbm_cyc_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
